// File: rtl/ub_affine_schedule_ctrl.sv
// rtl/ub_affine_schedule_ctrl.sv - affine-schedule loop-nest sequencer driving one unified-buffer port
module ub_affine_schedule_ctrl #(
    parameter int W           = 16,
    parameter int EXT_0       = 1,
    parameter int EXT_1       = 1,
    parameter int EXT_2       = 64,
    parameter int EXT_3       = 64,
    parameter int START_DELAY = 0,
    parameter int II          = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                start,
    input  logic                stall,
    output logic                en,
    output logic [3:0][W-1:0]   ctrl_vars,
    output logic                busy,
    output logic                done
);

    if (EXT_0 < 1 || EXT_1 < 1 || EXT_2 < 1 || EXT_3 < 1 || II < 1) begin : g_bad_range
        $error("ub_affine_schedule_ctrl: extents and II must be at least 1");
    end
    if (longint'(EXT_0) > (longint'(1) << W) || longint'(EXT_1) > (longint'(1) << W) ||
        longint'(EXT_2) > (longint'(1) << W) || longint'(EXT_3) > (longint'(1) << W)) begin : g_bad_width
        $error("ub_affine_schedule_ctrl: an extent does not fit in W bits");
    end

    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int IW = (II > 1) ? $clog2(II) : 1;
    localparam logic [DW-1:0] DLY_LAST = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [IW-1:0] II_LAST  = IW'(II - 1);
    localparam logic [3:0][W-1:0] LAST = {W'(EXT_3 - 1), W'(EXT_2 - 1), W'(EXT_1 - 1), W'(EXT_0 - 1)};

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

    state_t              state, state_nx;
    logic [DW-1:0]       dly_cnt, dly_nx;
    logic [IW-1:0]       ii_cnt, ii_nx;
    logic [3:0][W-1:0]   cv_nx, cv_inc;
    logic                last_iter;

    assign en   = (state == S_RUN) && (ii_cnt == '0) && !stall;
    assign busy = (state == S_DELAY) || (state == S_RUN);
    assign done = (state == S_DONE);

    // Odometer increment: innermost index [3] first; a carry surviving past [0] marks the final iteration.
    always_comb begin
        logic carry;
        cv_inc = ctrl_vars;
        carry  = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            if (carry) begin
                if (ctrl_vars[k] == LAST[k]) begin
                    cv_inc[k] = '0;
                end else begin
                    cv_inc[k] = ctrl_vars[k] + W'(1);
                    carry     = 1'b0;
                end
            end
        end
        last_iter = carry;
    end

    always_comb begin
        state_nx = state;
        dly_nx   = dly_cnt;
        ii_nx    = ii_cnt;
        cv_nx    = ctrl_vars;
        case (state)
            S_IDLE: begin
                cv_nx = '0;
                if (start) begin
                    if (START_DELAY == 0) begin
                        state_nx = S_RUN;
                    end else begin
                        state_nx = S_DELAY;
                        dly_nx   = '0;
                    end
                end
            end
            S_DELAY: begin
                if (!stall) begin
                    if (dly_cnt == DLY_LAST) begin
                        state_nx = S_RUN;
                        dly_nx   = '0;
                    end else begin
                        dly_nx = dly_cnt + DW'(1);
                    end
                end
            end
            S_RUN: begin
                if (en) begin
                    cv_nx = cv_inc;
                    ii_nx = (II > 1) ? IW'(1) : '0;
                    if (last_iter) begin
                        state_nx = S_DONE;
                        ii_nx    = '0;
                    end
                end else if (ii_cnt != '0 && !stall) begin
                    ii_nx = (ii_cnt == II_LAST) ? '0 : ii_cnt + IW'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                ii_nx    = '0;
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush) begin
            state_nx = S_IDLE;
            dly_nx   = '0;
            ii_nx    = '0;
            cv_nx    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dly_cnt   <= '0;
            ii_cnt    <= '0;
            ctrl_vars <= '0;
        end else begin
            state     <= state_nx;
            dly_cnt   <= dly_nx;
            ii_cnt    <= ii_nx;
            ctrl_vars <= cv_nx;
        end
    end

endmodule

// File: tb/tb_ub_affine_schedule_ctrl.sv
// tb/tb_ub_affine_schedule_ctrl.sv - scoreboard bench for ub_affine_schedule_ctrl
module tb_ub_affine_schedule_ctrl;

    typedef struct {
        int          id;
        int          cyc;
        logic [63:0] cv;
    } ev_t;

    logic             clk = 1'b0;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_bad = 0;
    bit               mon_on = 1'b0;
    ev_t              fq[$];
    ev_t              dq[$];

    logic             rst_v   [4];
    logic             flush_v [4];
    logic             start_v [4];
    logic             stall_v [4];
    logic             en_v    [4];
    logic             busy_v  [4];
    logic             done_v  [4];
    logic [3:0][15:0] cv_v    [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ub_affine_schedule_ctrl #(.W(16), .EXT_0(1), .EXT_1(1), .EXT_2(2), .EXT_3(3), .START_DELAY(0), .II(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .flush(flush_v[0]), .start(start_v[0]), .stall(stall_v[0]),
        .en(en_v[0]), .ctrl_vars(cv_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    ub_affine_schedule_ctrl #(.W(16), .EXT_0(1), .EXT_1(1), .EXT_2(1), .EXT_3(4), .START_DELAY(3), .II(2)) u_b (
        .clk(clk), .rst(rst_v[1]), .flush(flush_v[1]), .start(start_v[1]), .stall(stall_v[1]),
        .en(en_v[1]), .ctrl_vars(cv_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    ub_affine_schedule_ctrl #(.W(16), .EXT_0(1), .EXT_1(1), .EXT_2(1), .EXT_3(4), .START_DELAY(0), .II(1)) u_c (
        .clk(clk), .rst(rst_v[2]), .flush(flush_v[2]), .start(start_v[2]), .stall(stall_v[2]),
        .en(en_v[2]), .ctrl_vars(cv_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    ub_affine_schedule_ctrl u_d (
        .clk(clk), .rst(rst_v[3]), .flush(flush_v[3]), .start(start_v[3]), .stall(stall_v[3]),
        .en(en_v[3]), .ctrl_vars(cv_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fire(input int id, input int c, input int v0, input int v1, input int v2, input int v3);
        logic [3:0][15:0] e;
        e[0] = v0[15:0];
        e[1] = v1[15:0];
        e[2] = v2[15:0];
        e[3] = v3[15:0];
        fq.push_back('{id: id, cyc: c, cv: e});
    endtask

    task automatic push_done(input int id, input int c);
        dq.push_back('{id: id, cyc: c, cv: 64'd0});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fq.size() != 0 || dq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_fire", fq.size(), 0);
        chk("drain_done", dq.size(), 0);
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            for (int k = 0; k < 4; k++) begin
                if (en_v[k] === 1'b1) begin
                    if (fq.size() == 0) begin
                        chk("en_extra", k, 99);
                    end else begin
                        e = fq.pop_front();
                        chk("en_id", k, e.id);
                        chk("en_cyc", cyc, e.cyc);
                        chk("ctrl_vars", cv_v[k], e.cv);
                    end
                end
                if (done_v[k] === 1'b1) begin
                    if (dq.size() == 0) begin
                        chk("done_extra", k, 99);
                    end else begin
                        e = dq.pop_front();
                        chk("done_id", k, e.id);
                        chk("done_cyc", cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b1; flush_v[k] = 1'b0; start_v[k] = 1'b0; stall_v[k] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rst_en", en_v[k], 0);
            chk("rst_busy", busy_v[k], 0);
            chk("rst_done", done_v[k], 0);
            chk("rst_cv", cv_v[k], 0);
            rst_v[k] = 1'b0;
        end
        mon_on = 1'b1;
        tick();

        // basic 1x1x2x3 nest
        t0 = cyc;
        start_v[0] = 1'b1;
        for (int i = 0; i < 6; i++) push_fire(0, t0 + 1 + i, 0, 0, i / 3, i % 3);
        push_done(0, t0 + 7);
        for (int r = 1; r <= 8; r++) begin
            tick();
            start_v[0] = 1'b0;
            chk("a_busy", busy_v[0], (r <= 6) ? 1 : 0);
        end
        drain(20);

        // start delay 3, II 2
        t0 = cyc;
        start_v[1] = 1'b1;
        for (int i = 0; i < 4; i++) push_fire(1, t0 + 4 + 2 * i, 0, 0, 0, i);
        push_done(1, t0 + 11);
        tick();
        start_v[1] = 1'b0;
        drain(30);

        // stall for two cycles mid-run
        t0 = cyc;
        start_v[2] = 1'b1;
        push_fire(2, t0 + 1, 0, 0, 0, 0);
        push_fire(2, t0 + 2, 0, 0, 0, 1);
        push_fire(2, t0 + 5, 0, 0, 0, 2);
        push_fire(2, t0 + 6, 0, 0, 0, 3);
        push_done(2, t0 + 7);
        for (int r = 1; r <= 7; r++) begin
            tick();
            start_v[2] = 1'b0;
            stall_v[2] = (r == 3 || r == 4);
            if (stall_v[2]) chk("c_stall_cv3", cv_v[2][3], 2);
        end
        stall_v[2] = 1'b0;
        drain(20);

        // start pulsed during RUN and DONE must not disturb or repeat the pass
        t0 = cyc;
        start_v[0] = 1'b1;
        for (int i = 0; i < 6; i++) push_fire(0, t0 + 1 + i, 0, 0, i / 3, i % 3);
        push_done(0, t0 + 7);
        for (int r = 1; r <= 10; r++) begin
            tick();
            start_v[0] = (r == 3 || r == 7);
            chk("a2_busy", busy_v[0], (r <= 6) ? 1 : 0);
        end
        start_v[0] = 1'b0;
        drain(20);

        // reset together with start
        rst_v[3] = 1'b1;
        start_v[3] = 1'b1;
        tick();
        rst_v[3] = 1'b0;
        start_v[3] = 1'b0;
        chk("rs_busy", busy_v[3], 0);
        chk("rs_en", en_v[3], 0);
        chk("rs_done", done_v[3], 0);
        chk("rs_cv", cv_v[3], 0);
        tick();
        chk("rs_busy2", busy_v[3], 0);

        // flush coincident with the 100th fire
        t0 = cyc;
        start_v[3] = 1'b1;
        for (int i = 0; i < 100; i++) push_fire(3, t0 + 1 + i, 0, 0, i / 64, i % 64);
        tick();
        start_v[3] = 1'b0;
        repeat (99) tick();
        flush_v[3] = 1'b1;
        tick();
        flush_v[3] = 1'b0;
        chk("fl_busy", busy_v[3], 0);
        chk("fl_en", en_v[3], 0);
        chk("fl_cv", cv_v[3], 0);
        chk("fl_done", done_v[3], 0);
        repeat (4) tick();
        chk("fl_fires", fq.size(), 0);

        // full-size 64x64 pass after the flush
        t0 = cyc;
        start_v[3] = 1'b1;
        for (int i = 0; i < 4096; i++) push_fire(3, t0 + 1 + i, 0, 0, i / 64, i % 64);
        push_done(3, t0 + 4097);
        tick();
        start_v[3] = 1'b0;
        drain(5000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ub_affine_schedule_ctrl.md
Name: ub_affine_schedule_ctrl

Overview:
Sequencer that drives one port of a unified buffer (`*_ub`) in the down_sample pipeline. It generates the 4-deep loop-nest control variables (`ctrl_vars[3:0]`) and the matching `wen`/`ren` strobe for one compute op, following an affine schedule: a start delay, then one iteration every II cycles. One instance per op port; for example, `hw_input_stencil` write uses 1x1x64x64 and `avg_pool` read uses 1x1x32x32 with a delay.

Parameters:
- W, 16, width of each control variable.
- EXT_0, 1, extent of `ctrl_vars[0]` (outermost loop).
- EXT_1, 1, extent of `ctrl_vars[1]`.
- EXT_2, 64, extent of `ctrl_vars[2]`.
- EXT_3, 64, extent of `ctrl_vars[3]` (innermost loop).
- START_DELAY, 0, cycles between accepted `start` and the first iteration slot.
- II, 1, cycles between consecutive iterations (initiation interval).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous abort to IDLE; no `done` pulse is produced.
- start  in  1  begin one pass of the loop nest; sampled only in IDLE.
- stall  in  1  freezes all counters and suppresses `en`.
- en  out  1  iteration strobe; connects to the UB `*_wen` or `*_ren`.
- ctrl_vars  out  4xW  current loop indices, [0] outermost; connects to the UB `*_ctrl_vars`.
- busy  out  1  high in DELAY and RUN.
- done  out  1  one-cycle pulse after the last iteration.

Behaviour:
- Elaboration checks: every EXT_k >= 1; II >= 1; every EXT_k <= 2^W.
- Reset (`rst`=1 at a clock edge):
  - state = IDLE; `ctrl_vars` = 0.
  - delay counter and II counter = 0.
  - `en`, `busy`, `done` = 0.
  - `rst` overrides `flush`, `start` and `stall`.
- `flush`:
  - Same effect as `rst` on state and counters.
  - Lower priority than `rst`, higher than everything else.
- States: IDLE, DELAY, RUN, DONE.
- IDLE:
  - `start`=1 with START_DELAY=0 -> RUN.
  - `start`=1 with START_DELAY>0 -> DELAY, delay counter = 0.
  - `ctrl_vars` held at 0.
- DELAY:
  - Delay counter increments each non-stalled cycle.
  - When the counter reaches START_DELAY-1 -> RUN.
  - `stall` freezes the counter.
- RUN:
  - `en` = (state==RUN) && (ii_cnt==0) && !`stall`. This is combinational from registered state and counters.
  - On a cycle with `en`=1 ("fire"):
    - `ctrl_vars[3]` increments.
    - When it equals EXT_3-1 it wraps to 0 and carries into `ctrl_vars[2]`, and so on up to [0]. Mixed-radix increment, odometer order.
    - If II>1, `ii_cnt` becomes 1.
  - When `ii_cnt`!=0 and no stall: `ii_cnt` increments, wrapping to 0 after II-1.
  - `stall` freezes `ii_cnt` and `ctrl_vars`.
  - A fire with all `ctrl_vars[k]` == EXT_k-1 is the last iteration -> DONE. `ctrl_vars` wrap to all-zero on that edge.
- DONE:
  - `done`=1 for exactly one cycle, then -> IDLE.
  - `start` in DONE is ignored.
- `start` outside IDLE is ignored and never queued.
- `busy` = (state==DELAY || state==RUN).
- Timing without stalls, with `start` high in cycle t (IDLE):
  - First `en` in cycle t+1+START_DELAY.
  - Iteration i (0-based) fires at t+1+START_DELAY+i*II.
  - `done` occurs in the cycle after the last fire.
  - Total `en` count = EXT_0*EXT_1*EXT_2*EXT_3.
- Stall inserted in RUN: every subsequent event shifts by the number of stalled cycles. No iteration is skipped or duplicated.
- `ctrl_vars` are valid whenever `en`=1 and are stable while stalled.
- EXT_k=1 dimensions stay at 0 for the whole pass.

Test Plan:
- Basic nest: EXT=1,1,2,3, II=1, DELAY=0, `start` at cycle 5.
  - `en` high in cycles 6..11.
  - (`ctrl_vars[2]`,`ctrl_vars[3]`) sequence = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - `done` at cycle 12; `busy` high in 6..11.
- Delay and II: EXT=1,1,1,4, DELAY=3, II=2, `start` at cycle 0.
  - `en` at cycles 4,6,8,10 with `ctrl_vars[3]`=0..3.
  - `done` at 11.
- Stall: EXT=1,1,1,4, II=1, `stall` high in cycles 3-4 after `start` at 0.
  - `en` at 1,2,5,6.
  - `ctrl_vars[3]` held at 2 during the stall.
  - `done` at 7.
- Flush mid-run: 1x1x64x64, assert `flush` after the 100th fire.
  - Next cycle: `busy`=0, `en`=0, `ctrl_vars`=0, no `done`.
  - A new `start` restarts from (0,0,0,0).
- Reset and ignored start: `start` pulsed during RUN (no effect on the sequence). `rst` asserted together with `start` (stays IDLE, all outputs 0).
- Full-size write nest: 1x1x64x64, II=1 -> exactly 4096 `en` pulses. Last `ctrl_vars` = (0,0,63,63); `done` the cycle after.
